// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester ports and the asynchronous SRAM pins.
// The arbiter takes the slave view; requesters and the SRAM device take the master view.
interface sram_arbiter_if;
  logic        a_req;
  logic [19:0] a_addr;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        a_rvalid;

  logic        b_req;
  logic        b_we;
  logic [19:0] b_addr;
  logic [15:0] b_wdata;
  logic [1:0]  b_be;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        b_rvalid;

  logic [19:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  a_req, a_addr,
    output a_ack, a_rdata, a_rvalid,
    input  b_req, b_we, b_addr, b_wdata, b_be,
    output b_ack, b_rdata, b_rvalid,
    output sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_dq_i,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output a_req, a_addr,
    input  a_ack, a_rdata, a_rvalid,
    output b_req, b_we, b_addr, b_wdata, b_be,
    input  b_ack, b_rdata, b_rvalid,
    input  sram_addr, sram_dq_o, sram_dq_oe,
    output sram_dq_i,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous 16-bit SRAM: video read port A has priority,
// CPU port B is guaranteed a slot after A_BURST_MAX consecutive A grants while it waits.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int A_BURST_MAX   = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cyc_cnt;
  logic [7:0]  a_cnt;
  logic        owner_b;
  logic        write_q;
  logic [1:0]  be_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic        grant_a;
  logic        grant_b;
  logic        last_access;

  // Port A wins ties unless B has waited through a full A burst.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (bus.a_req && !(bus.b_req && (a_cnt == 8'(A_BURST_MAX))))
        grant_a = 1'b1;
      else if (bus.b_req)
        grant_b = 1'b1;
    end
  end

  assign last_access = (state == ACCESS) && (cyc_cnt == 4'(ACCESS_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_a || grant_b) state_next = ACCESS;
      ACCESS:  if (last_access) state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt      <= '0;
      a_cnt        <= '0;
      owner_b      <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= 2'b11;
      addr_q       <= '0;
      wdata_q      <= '0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.a_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      bus.a_ack    <= grant_a;
      bus.b_ack    <= grant_b;
      bus.a_rvalid <= last_access && !write_q && !owner_b;
      bus.b_rvalid <= last_access && !write_q && owner_b;
      cyc_cnt      <= (state == ACCESS) ? cyc_cnt + 4'd1 : 4'd0;
      if (grant_a) begin
        owner_b <= 1'b0;
        write_q <= 1'b0;
        be_q    <= 2'b11;
        addr_q  <= bus.a_addr;
        if (!bus.b_req)
          a_cnt <= '0;
        else if (a_cnt != 8'(A_BURST_MAX))
          a_cnt <= a_cnt + 8'd1;
      end
      if (grant_b) begin
        owner_b <= 1'b1;
        write_q <= bus.b_we;
        be_q    <= bus.b_be;
        addr_q  <= bus.b_addr;
        wdata_q <= bus.b_wdata;
        a_cnt   <= '0;
      end
      if (last_access && !write_q) begin
        if (owner_b)
          bus.b_rdata <= bus.sram_dq_i;
        else
          bus.a_rdata <= bus.sram_dq_i;
      end
    end
  end

  // Strobes come straight from state so an asynchronous reset releases the SRAM at once.
  always_comb begin
    bus.sram_ce_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_ub_n  = 1'b1;
    bus.sram_lb_n  = 1'b1;
    bus.sram_dq_oe = 1'b0;
    if (state == ACCESS) begin
      bus.sram_ce_n = 1'b0;
      bus.sram_oe_n = write_q;
      bus.sram_we_n = !write_q;
      bus.sram_ub_n = write_q ? !be_q[1] : 1'b0;
      bus.sram_lb_n = write_q ? !be_q[0] : 1'b0;
    end
    if ((state == ACCESS) || (state == TURN))
      bus.sram_dq_oe = write_q;
  end

  assign bus.sram_addr = addr_q;
  assign bus.sram_dq_o = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a behavioural SRAM device plus a transaction-level
// reference (word memory, per-cycle strobe timetable, burst-fairness rule).
module tb_sram_arbiter;

  localparam int ACC  = 2;
  localparam int BMAX = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  sram_arbiter_if bus ();

  sram_arbiter #(
    .ACCESS_CYCLES(ACC),
    .A_BURST_MAX  (BMAX)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];
  logic [15:0] env_w;
  logic [15:0] exp_rdata_a = '0;
  logic [15:0] exp_rdata_b = '0;

  function automatic logic [15:0] init_word(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] sram_peek(input logic [19:0] a);
    return sram_mem.exists(int'(a)) ? sram_mem[int'(a)] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_peek(input logic [19:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  // SRAM device: settles read data and commits writes mid-cycle, away from the DUT's edge.
  always @(negedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_oe_n)
      bus.sram_dq_i = sram_peek(bus.sram_addr);
    else
      bus.sram_dq_i = 16'hDEAD;
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
      env_w = sram_peek(bus.sram_addr);
      if (!bus.sram_lb_n) env_w[7:0]  = bus.sram_dq_o[7:0];
      if (!bus.sram_ub_n) env_w[15:8] = bus.sram_dq_o[15:8];
      sram_mem[int'(bus.sram_addr)] = env_w;
    end
  end

  // One access from an IDLE negedge, checked cycle by cycle against the expected timetable.
  task automatic do_access(input bit is_b, input bit we, input logic [19:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
    logic [15:0] word;
    logic [9:0]  obs;
    logic [9:0]  exp;
    bit          in_acc;
    if (is_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data; bus.b_be = be;
    end else begin
      bus.a_req = 1'b1; bus.a_addr = addr;
    end
    if (we) begin
      word = ref_peek(addr);
      if (be[0]) word[7:0]  = data[7:0];
      if (be[1]) word[15:8] = data[15:8];
      ref_mem[int'(addr)] = word;
    end else if (is_b) begin
      exp_rdata_b = ref_peek(addr);
    end else begin
      exp_rdata_a = ref_peek(addr);
    end
    for (int k = 1; k <= ACC + 2; k++) begin
      @(negedge clk);
      in_acc = (k <= ACC);
      exp = {!in_acc, !(in_acc && !we), !(in_acc && we),
             in_acc ? (we ? !be[1] : 1'b0) : 1'b1,
             in_acc ? (we ? !be[0] : 1'b0) : 1'b1,
             we && (k <= ACC + 1),
             !is_b && (k == 1), is_b && (k == 1),
             !is_b && !we && (k == ACC + 1), is_b && !we && (k == ACC + 1)};
      obs = {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
             bus.sram_dq_oe, bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL strobes addr=%h k=%0d got %b want %b", addr, k, obs, exp);
      end
      total++;
      if (bus.sram_addr !== addr) begin
        bad++;
        $display("[TB] FAIL sram_addr k=%0d got %h want %h", k, bus.sram_addr, addr);
      end
      if (we && k <= ACC + 1) begin
        total++;
        if (bus.sram_dq_o !== data) begin
          bad++;
          $display("[TB] FAIL sram_dq_o k=%0d got %h want %h", k, bus.sram_dq_o, data);
        end
      end
      if (k == ACC + 1) begin
        total++;
        if ({bus.a_rdata, bus.b_rdata} !== {exp_rdata_a, exp_rdata_b}) begin
          bad++;
          $display("[TB] FAIL rdata addr=%h got a=%h b=%h want a=%h b=%h", addr,
                   bus.a_rdata, bus.b_rdata, exp_rdata_a, exp_rdata_b);
        end
      end
      if (k == 1) begin
        if (is_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    #1 reset_n = 1'b0;
    #1;
    obs = {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
           bus.sram_dq_oe, bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid};
    total++;
    if (obs !== 10'b11111_00000) begin
      bad++; $display("[TB] FAIL reset_strobes got %b want %b", obs, 10'b11111_00000);
    end
    total++;
    if ({bus.sram_addr, bus.sram_dq_o, bus.a_rdata, bus.b_rdata} !== 68'd0) begin
      bad++;
      $display("[TB] FAIL reset_regs got addr=%h dq_o=%h a=%h b=%h want zeros",
               bus.sram_addr, bus.sram_dq_o, bus.a_rdata, bus.b_rdata);
    end
    repeat (3) @(negedge clk);
    obs = {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n,
           bus.sram_dq_oe, bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid};
    total++;
    if (obs !== 10'b11111_00000) begin
      bad++; $display("[TB] FAIL reset_held got %b want %b", obs, 10'b11111_00000);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_write_read_b();
    do_access(1'b1, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
    do_access(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b00);
  endtask

  task automatic test_byte_enables();
    do_access(1'b1, 1'b1, 20'h00010, 16'h12AB, 2'b01);
    do_access(1'b1, 1'b1, 20'h00011, 16'h3456, 2'b10);
    do_access(1'b1, 1'b1, 20'h00010, 16'hFFFF, 2'b00);
    do_access(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b00);
    do_access(1'b0, 1'b0, 20'h00011, 16'h0000, 2'b00);
  endtask

  task automatic test_random_single();
    bit is_b;
    bit we;
    for (int i = 0; i < 12; i++) begin
      is_b = 1'($urandom_range(0, 1));
      we   = is_b ? 1'($urandom_range(0, 1)) : 1'b0;
      do_access(is_b, we, 20'h00100 + 20'($urandom_range(0, 7)), 16'($urandom),
                2'($urandom_range(0, 3)));
    end
  endtask

  // Both ports hammer continuously; grants must follow the burst-fairness pattern.
  task automatic test_burst();
    int seen;
    int cyc;
    int last_cyc;
    bit grants[$];
    bus.a_addr = 20'h00101; bus.b_addr = 20'h00102; bus.b_we = 1'b0;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    seen = 0; cyc = 0; last_cyc = -1;
    while (seen < 27 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      total++;
      if (((bus.a_ack & bus.b_ack) | (bus.a_rvalid & bus.b_rvalid)) !== 1'b0) begin
        bad++; $display("[TB] FAIL overlap cyc=%0d got 1 want 0", cyc);
      end
      if (bus.a_ack || bus.b_ack) begin
        grants.push_back(bus.b_ack);
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc != ACC + 2) begin
            bad++; $display("[TB] FAIL burst_spacing got %0d want %0d", cyc - last_cyc, ACC + 2);
          end
        end
        last_cyc = cyc;
        seen++;
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    total++;
    if (seen != 27) begin
      bad++; $display("[TB] FAIL burst_count got %0d want 27", seen);
    end
    foreach (grants[i]) begin
      total++;
      if (grants[i] != ((i % (BMAX + 1)) == BMAX)) begin
        bad++; $display("[TB] FAIL burst_order grant=%0d got b=%0d want b=%0d", i, grants[i],
                        (i % (BMAX + 1)) == BMAX);
      end
    end
    repeat (ACC + 1) @(negedge clk);
    exp_rdata_a = ref_peek(20'h00101);
    exp_rdata_b = ref_peek(20'h00102);
  endtask

  task automatic test_a_only();
    int acks;
    int last_cyc;
    bus.a_addr = 20'h00103; bus.a_req = 1'b1;
    acks = 0; last_cyc = -1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      total++;
      if (bus.b_ack !== 1'b0) begin
        bad++; $display("[TB] FAIL a_only_b_ack cyc=%0d got %b want 0", cyc, bus.b_ack);
      end
      if (bus.a_ack) begin
        if (last_cyc >= 0) begin
          total++;
          if (cyc - last_cyc != ACC + 2) begin
            bad++; $display("[TB] FAIL a_only_spacing got %0d want %0d", cyc - last_cyc, ACC + 2);
          end
        end
        last_cyc = cyc;
        acks++;
      end
    end
    bus.a_req = 1'b0;
    total++;
    if (acks != 6) begin
      bad++; $display("[TB] FAIL a_only_count got %0d want 6", acks);
    end
    repeat (ACC + 1) @(negedge clk);
    exp_rdata_a = ref_peek(20'h00103);
  endtask

  // Reset in the middle of a write must release the bus instantly and drop the access.
  task automatic test_reset_mid_access();
    logic [15:0] d;
    d = 16'($urandom);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 20'h00200; bus.b_wdata = d; bus.b_be = 2'b11;
    @(negedge clk);
    total++;
    if (bus.b_ack !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_first_ack got %b want 1", bus.b_ack);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.sram_ce_n, bus.sram_we_n, bus.sram_dq_oe} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL mid_async_release got %b want 110",
               {bus.sram_ce_n, bus.sram_we_n, bus.sram_dq_oe});
    end
    exp_rdata_a = '0;
    exp_rdata_b = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata} !== 36'd0) begin
        bad++;
        $display("[TB] FAIL mid_in_reset got acks=%b%b rv=%b%b a=%h b=%h want zeros",
                 bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid, bus.a_rdata, bus.b_rdata);
      end
    end
    reset_n = 1'b1;
    do_access(1'b1, 1'b1, 20'h00200, d, 2'b11);
  endtask

  // Random contention with persistent requests, predicted by the burst-fairness rule.
  task automatic test_random_contention();
    bit pend_a;
    bit pend_b;
    int streak;
    logic [19:0] pa_addr;
    logic [19:0] pb_addr;
    logic [15:0] pb_data;
    logic [1:0]  pb_be;
    bit          pb_we;
    pend_a = 0; pend_b = 0; streak = 0;
    for (int t = 0; t < 40 || pend_a || pend_b; t++) begin
      if (t < 40 && !pend_a && $urandom_range(0, 7) != 0) begin
        pend_a = 1; pa_addr = 20'h00100 + 20'($urandom_range(0, 7));
        bus.a_addr = pa_addr; bus.a_req = 1'b1;
      end
      if (t < 40 && !pend_b && $urandom_range(0, 1) != 0) begin
        pend_b = 1; pb_addr = 20'h00100 + 20'($urandom_range(0, 7));
        pb_we = 1'($urandom_range(0, 1)); pb_data = 16'($urandom); pb_be = 2'($urandom_range(0, 3));
        bus.b_req = 1'b1; bus.b_we = pb_we; bus.b_addr = pb_addr; bus.b_wdata = pb_data; bus.b_be = pb_be;
      end
      if (!pend_a && !pend_b) begin
        @(negedge clk);
        total++;
        if ({bus.a_ack, bus.b_ack} !== 2'b00) begin
          bad++; $display("[TB] FAIL idle_ack t=%0d got %b want 00", t, {bus.a_ack, bus.b_ack});
        end
        continue;
      end
      if (pend_b && (!pend_a || streak == BMAX)) begin
        streak = 0;
        pend_b = 0;
        do_access(1'b1, pb_we, pb_addr, pb_data, pb_be);
      end else begin
        streak = pend_b ? ((streak == BMAX) ? BMAX : streak + 1) : 0;
        pend_a = 0;
        do_access(1'b0, 1'b0, pa_addr, 16'h0000, 2'b00);
      end
    end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_be = 2'b00;
    bus.sram_dq_i = 16'hDEAD;
    test_reset();
    test_write_read_b();
    test_byte_enables();
    test_random_single();
    test_burst();
    test_a_only();
    test_reset_mid_access();
    test_random_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL provide parameter ACCESS_CYCLES, default 2: cycles per access with the SRAM strobes asserted, legal range 1..15.
REQ-002 The block SHALL provide parameter A_BURST_MAX, default 8: maximum consecutive port-A grants while port B waits, legal range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are as follows.
- clk  in  1  sole clock, all state on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-004 Port A (video, read-only) SHALL have these ports:
- a_req  in  1  read request, held until a_ack.
- a_addr  in  20  word address.
- a_ack  out  1  one-cycle acceptance pulse.
- a_rdata  out  16  read data.
- a_rvalid  out  1  one-cycle read-data strobe.
REQ-005 Port B (CPU, read/write) SHALL have these ports:
- b_req  in  1  request, held until b_ack.
- b_we  in  1  1 = write, 0 = read.
- b_addr  in  20  word address.
- b_wdata  in  16  write data.
- b_be  in  2  byte enables; [1] upper, [0] lower.
- b_ack  out  1  one-cycle acceptance pulse.
- b_rdata  out  16  read data.
- b_rvalid  out  1  one-cycle read-data strobe.
REQ-006 The SRAM side SHALL have these ports:
- sram_addr  out  20  SRAM address.
- sram_dq_o  out  16  write data.
- sram_dq_oe  out  1  data bus drive enable.
- sram_dq_i  in  16  read data.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Function
REQ-007 The FSM SHALL have three states, IDLE, ACCESS and TURN, with transitions IDLE->ACCESS on a grant, ACCESS->TURN after ACCESS_CYCLES cycles, and TURN->IDLE always.
REQ-008 Arbitration SHALL occur only in IDLE; with no request, the FSM remains in IDLE.
REQ-009 Port A SHALL win when both ports request, except when a_cnt == A_BURST_MAX and b_req=1, in which case port B wins.
REQ-010 The a_cnt register SHALL update on each grant as follows:
- A granted while b_req=1: increment, saturating at A_BURST_MAX.
- A granted while b_req=0: clear.
- Any B grant: clear.
REQ-011 On a grant at IDLE cycle t, the block SHALL register address, data, byte enables and direction, and pulse the winning port's ack during cycle t+1 (first ACCESS cycle).
REQ-012 In ACCESS, the block SHALL drive sram_ce_n=0, with a read driving sram_oe_n=0 and a write driving sram_we_n=0, for all ACCESS_CYCLES cycles.
REQ-013 In ACCESS, the byte strobes SHALL be driven as follows:
- Port-A reads and all port-B reads: sram_ub_n=sram_lb_n=0.
- Port-B writes: sram_ub_n=~b_be[1], sram_lb_n=~b_be[0].
REQ-014 A port-B write with b_be=00 SHALL still run a full cycle and be acked, with both byte strobes high.
REQ-015 For a write, sram_dq_oe SHALL be 1 and sram_dq_o SHALL be the latched data throughout ACCESS and TURN; sram_dq_oe SHALL be 0 in every other case.
REQ-016 For a read, the block SHALL sample sram_dq_i into the owning port's rdata on the last ACCESS edge.
REQ-017 For a read, the owning port's rvalid SHALL pulse during TURN, i.e. cycle t+1+ACCESS_CYCLES.
REQ-018 Each port's rdata SHALL hold until that port's next read completes.
REQ-019 In TURN, all strobes SHALL be high and sram_addr SHALL hold (address/data hold time and bus turnaround).
REQ-020 In IDLE, all strobes SHALL be high, sram_dq_oe=0, and sram_addr SHALL hold its last value.
REQ-021 Back-to-back throughput SHALL be one access per ACCESS_CYCLES+2 cycles.
REQ-022 A requester SHALL be able to keep req high after ack to request again; the request is re-arbitrated at the next IDLE.
REQ-023 ack and rvalid SHALL never be asserted for both ports in the same cycle.

Reset
REQ-024 While reset_n=0, the block SHALL hold the following values, asynchronously and without waiting for clk:
- state IDLE, a_cnt=0.
- All SRAM strobes 1, sram_dq_oe=0.
- sram_addr=0, sram_dq_o=0.
- acks=0, rvalids=0, rdatas=0.
REQ-025 Reset asserted mid-access SHALL abort the access, with no later ack or rvalid for it.
REQ-026 After reset release, the first edge SHALL start arbitration from IDLE.

Verification
REQ-027 B write, addr 0x00010, data 0xBEEF, be=11, ACCESS_CYCLES=2, b_req at IDLE cycle 0 -> expected response:
- b_ack in cycle 1.
- ce_n/we_n low in cycles 1-2; TURN in cycle 3; IDLE in cycle 4.
- sram_dq_o=0xBEEF with dq_oe=1 in cycles 1-3.
REQ-028 B read of addr 0x00010, SRAM model returning 0xBEEF -> oe_n low in cycles 1-2; b_rvalid in cycle 3 only, with b_rdata=0xBEEF; dq_oe=0 throughout.
REQ-029 a_req and b_req held high continuously, A_BURST_MAX=8 -> grants repeat 8xA, 1xB; no ack overlap.
REQ-030 B write with be=01, data 0x12AB -> sram_lb_n=0 and sram_ub_n=1 during ACCESS; a_req alone held high -> a grant every 4 cycles, B never granted.
REQ-031 reset_n dropped in the 2nd ACCESS cycle of a write -> ce_n and we_n go to 1 and dq_oe to 0 before the next clk edge; no ack or rvalid follows; a still-held req is serviced fresh after release.
